// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and shared types for the encoder and control decoder.
// Optional build macro: INSTR_ENC_OPCODE_CHECK_EN.
package mips_isa_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic logic is_known(
    input logic [5:0] op
  );
    logic hit;
    hit = 1'b0;
    unique case (1'b1)
      op == R_TYPE: hit = 1'b1;
      op == ADDI:   hit = 1'b1;
      op == ORI:    hit = 1'b1;
      op == ANDI:   hit = 1'b1;
      op == LUI:    hit = 1'b1;
      op == SW:     hit = 1'b1;
      op == LW:     hit = 1'b1;
      op == BEQ:    hit = 1'b1;
      op == BNE:    hit = 1'b1;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input handshake plus program-memory write port of the encoder.
// Optional build macro: INSTR_ENC_OPCODE_CHECK_EN.
interface instr_encoder_if;

  logic        enc_valid_i;
  logic        enc_ready_o;
  logic [5:0]  opcode_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [4:0]  shamt_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic        load_i;
  logic [31:0] load_addr_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        illegal_o;
  logic [15:0] word_cnt_o;

  modport slave (
    input  enc_valid_i,
    output enc_ready_o,
    input  opcode_i,
    input  rs_i,
    input  rt_i,
    input  rd_i,
    input  shamt_i,
    input  funct_i,
    input  imm_i,
    input  load_i,
    input  load_addr_i,
    output mem_valid_o,
    input  mem_ready_i,
    output mem_addr_o,
    output mem_wdata_o,
    output illegal_o,
    output word_cnt_o
  );

  modport master (
    output enc_valid_i,
    input  enc_ready_o,
    output opcode_i,
    output rs_i,
    output rt_i,
    output rd_i,
    output shamt_i,
    output funct_i,
    output imm_i,
    output load_i,
    output load_addr_i,
    input  mem_valid_o,
    output mem_ready_i,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  illegal_o,
    input  word_cnt_o
  );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction fields to a 32-bit MIPS word.
// Optional build macro: INSTR_ENC_OPCODE_CHECK_EN (drives legal).
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  instr_fields_t      fields,
  output logic [WORD_W-1:0]  word,
  output logic               legal
);

  always_comb begin
    word = {fields.opcode, fields.rs,
            fields.rt, fields.imm};
    unique case (1'b1)
      fields.opcode == R_TYPE:
        word = {fields.opcode, fields.rs,
                fields.rt, fields.rd,
                fields.shamt, fields.funct};
      fields.opcode == LUI:
        word = {fields.opcode, 5'd0,
                fields.rt, fields.imm};
      default: ;
    endcase
  end

`ifdef INSTR_ENC_OPCODE_CHECK_EN
  assign legal = is_known(fields.opcode);
`else
  // Unknown opcodes fall through to I-format above.
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs fields, stamps addresses, writes program memory.
// Optional build macro: INSTR_ENC_OPCODE_CHECK_EN (drop illegal opcodes).
module instr_encoder (
  input  logic            clk_i,
  input  logic            rst_n_i,
  instr_encoder_if.slave  bus
);
  import mips_isa_pkg::*;

  enc_state_e          state;
  enc_state_e          state_nxt;
  instr_fields_t       fields;
  logic [WORD_W-1:0]   word;
  logic                legal;
  logic                full;
  logic                accept;
  logic                take;
  logic                mem_valid;
  logic                wr_done;
  logic [31:0]         addr_cnt;
  logic [31:0]         load_base;
  logic [31:0]         stamp;
  logic [31:0]         addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [15:0]         word_cnt;

  assign fields = '{
    opcode: bus.opcode_i,
    rs:     bus.rs_i,
    rt:     bus.rt_i,
    rd:     bus.rd_i,
    shamt:  bus.shamt_i,
    funct:  bus.funct_i,
    imm:    bus.imm_i
  };

  instr_field_pack u_pack (
    .fields (fields),
    .word   (word),
    .legal  (legal)
  );

  assign full      = (state == FULL);
  assign bus.enc_ready_o = !full || bus.mem_ready_i;
  assign accept    = bus.enc_valid_i && bus.enc_ready_o;
  assign take      = accept && legal;
  assign wr_done   = mem_valid && bus.mem_ready_i;
  assign load_base = {bus.load_addr_i[31:2], 2'b00};
  // A load coinciding with an accept stamps this very word.
  assign stamp     = bus.load_i ? load_base : addr_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL: begin
        if (take)                 state_nxt = FULL;
        else if (bus.mem_ready_i) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    mem_valid = (state == FULL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wdata_q <= '0;
      addr_q  <= '0;
    end else if (take) begin
      wdata_q <= word;
      addr_q  <= stamp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_cnt <= '0;
    end else if (take) begin
      addr_cnt <= stamp + 32'd4;
    end else if (bus.load_i) begin
      addr_cnt <= load_base;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      word_cnt <= '0;
    end else if (wr_done && word_cnt != 16'hFFFF) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

`ifdef INSTR_ENC_OPCODE_CHECK_EN
  logic illegal_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
    end
  end

  assign bus.illegal_o = illegal_q;
`else
  assign bus.illegal_o = 1'b0;
`endif

  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.word_cnt_o  = word_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, queued expectations.
// Optional build macro: INSTR_ENC_OPCODE_CHECK_EN.
module tb_instr_encoder;
  import mips_isa_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;

  always #5 clk = ~clk;

  instr_encoder_if bus();

  instr_encoder dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Monitor: pop on handshake, compare against head while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.mem_valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h@%h required=none",
                 bus.mem_wdata_o, bus.mem_addr_o);
      end else if (bus.mem_ready_i) begin
        e = q.pop_front();
        chk("wr_addr", bus.mem_addr_o, e.addr);
        chk("wr_data", bus.mem_wdata_o, e.data);
      end else begin
        chk("stall_addr", bus.mem_addr_o, q[0].addr);
        chk("stall_data", bus.mem_wdata_o, q[0].data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0]  op,
                      input logic [4:0]  rs,
                      input logic [4:0]  rt,
                      input logic [4:0]  rd,
                      input logic [4:0]  sh,
                      input logic [5:0]  fn,
                      input logic [15:0] imm,
                      input logic        ld,
                      input logic [31:0] la,
                      input logic [31:0] exp_word,
                      input logic [31:0] exp_addr,
                      input bit          expect_write);
    bit done;
    done = 1'b0;
    bus.opcode_i    = op;
    bus.rs_i        = rs;
    bus.rt_i        = rt;
    bus.rd_i        = rd;
    bus.shamt_i     = sh;
    bus.funct_i     = fn;
    bus.imm_i       = imm;
    bus.load_i      = ld;
    bus.load_addr_i = la;
    bus.enc_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.enc_ready_o) begin
        done = 1'b1;
        if (expect_write) begin
          q.push_back('{exp_addr, exp_word});
          writes++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_ready required=ready op=%h", op);
    end
    tick();
    bus.enc_valid_i = 1'b0;
    bus.load_i      = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = (q.size() == 0);
    for (int i = 0; i < 50 && !empty; i++) begin
      @(negedge clk);
      empty = (q.size() == 0);
    end
    if (!empty) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    tick();
  endtask

  task automatic load_only(input logic [31:0] la);
    bus.load_i      = 1'b1;
    bus.load_addr_i = la;
    tick();
    bus.load_i      = 1'b0;
  endtask

  initial begin
    bus.enc_valid_i = 1'b0;
    bus.opcode_i    = '0;
    bus.rs_i        = '0;
    bus.rt_i        = '0;
    bus.rd_i        = '0;
    bus.shamt_i     = '0;
    bus.funct_i     = '0;
    bus.imm_i       = '0;
    bus.load_i      = 1'b0;
    bus.load_addr_i = '0;
    bus.mem_ready_i = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("rst_ready", 32'(bus.enc_ready_o), 32'd1);
    chk("rst_cnt", 32'(bus.word_cnt_o), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    load_only(32'h0040_0000);
    send(ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5,
         1'b0, 32'd0, 32'h2008_0005, 32'h0040_0000, 1'b1);
    @(negedge clk);
    chk("latency_valid", 32'(bus.mem_valid_o), 32'd1);
    tick();
    drain();

    // Held word must vanish on reset.
    bus.mem_ready_i = 1'b0;
    send(ADDI, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'd3,
         1'b0, 32'd0, 32'h2003_0003, 32'h0040_0004, 1'b1);
    rst_n = 1'b0;
    tick();
    q.delete();
    writes = 0;
    @(negedge clk);
    chk("rst_full_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("rst_full_cnt", 32'(bus.word_cnt_o), 32'd0);
    bus.mem_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    load_only(32'h0040_0000);
    send(R_TYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0,
         1'b0, 32'd0, 32'h0109_5020, 32'h0040_0000, 1'b1);
    send(LW, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4,
         1'b0, 32'd0, 32'h8FA8_0004, 32'h0040_0004, 1'b1);
    drain();
    @(negedge clk);
    chk("word_cnt_2", 32'(bus.word_cnt_o), 32'd2);
    tick();

    send(LUI, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001,
         1'b0, 32'd0, 32'h3C01_1001, 32'h0040_0008, 1'b1);
    drain();

    bus.mem_ready_i = 1'b0;
    send(SW, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0010,
         1'b0, 32'd0, 32'hAC22_0010, 32'h0040_000C, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 32'(bus.enc_ready_o), 32'd0);
    end
    tick();
    bus.mem_ready_i = 1'b1;
    send(BEQ, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hFFFF,
         1'b0, 32'd0, 32'h1064_FFFF, 32'h0040_0010, 1'b1);
    send(BNE, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0001,
         1'b0, 32'd0, 32'h1400_0001, 32'h0040_0014, 1'b1);
    @(negedge clk);
    chk("no_bubble", 32'(bus.mem_valid_o), 32'd1);
    tick();
    send(ORI, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h00FF,
         1'b0, 32'd0, 32'h3421_00FF, 32'h0040_0018, 1'b1);
    send(ANDI, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'hF0F0,
         1'b0, 32'd0, 32'h3043_F0F0, 32'h0040_001C, 1'b1);
    drain();

    // Load with accept; low address bits are masked off.
    send(ADDI, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1,
         1'b1, 32'hFFFF_FFFE, 32'h2021_0001, 32'hFFFF_FFFC, 1'b1);
    send(ADDI, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0,
         1'b0, 32'd0, 32'h2000_0000, 32'h0000_0000, 1'b1);
    drain();

    bus.mem_ready_i = 1'b0;
    send(ADDI, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'd2,
         1'b0, 32'd0, 32'h2002_0002, 32'h0000_0004, 1'b1);
    load_only(32'h0000_0100);
    repeat (2) @(negedge clk);
    tick();
    bus.mem_ready_i = 1'b1;
    send(ORI, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd7,
         1'b0, 32'd0, 32'h3405_0007, 32'h0000_0100, 1'b1);
    drain();

`ifdef INSTR_ENC_OPCODE_CHECK_EN
    send(6'h3F, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3,
         1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("illegal_pulse", 32'(bus.illegal_o), 32'd1);
    chk("illegal_nowr", 32'(bus.mem_valid_o), 32'd0);
    @(negedge clk);
    chk("illegal_end", 32'(bus.illegal_o), 32'd0);
    tick();
    send(ADDI, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd9,
         1'b0, 32'd0, 32'h2000_0009, 32'h0000_0104, 1'b1);
`else
    send(6'h3F, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3,
         1'b0, 32'd0, 32'hFC22_0003, 32'h0000_0104, 1'b1);
    @(negedge clk);
    chk("illegal_tied", 32'(bus.illegal_o), 32'd0);
    tick();
    send(ADDI, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd9,
         1'b0, 32'd0, 32'h2000_0009, 32'h0000_0108, 1'b1);
`endif
    drain();
    tick();
    @(negedge clk);
    chk("word_cnt_final", 32'(bus.word_cnt_o), 32'(writes));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have these ports, clock and reset first: clk_i  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have: rst_n_i  in  1  synchronous, active-low reset.
REQ-003 SHALL have: enc_valid_i  in  1, plus enc_ready_o  out  1; together they form the field-input handshake.
REQ-004 SHALL have: opcode_i  in  6, rs_i  in  5, rt_i  in  5, rd_i  in  5, shamt_i  in  5, funct_i  in  6, imm_i  in  16; these are the instruction fields.
REQ-005 SHALL have: load_i  in  1 and load_addr_i  in  32; these set the write address.
REQ-006 SHALL have: mem_valid_o  out  1, mem_ready_i  in  1, mem_addr_o  out  32, mem_wdata_o  out  32; these form the program-memory write port.
REQ-007 SHALL have: illegal_o  out  1, a one-cycle pulse on a rejected opcode.
REQ-008 SHALL have: word_cnt_o  out  16, the count of words written.

Function
REQ-009 SHALL transfer fields when enc_valid_i && enc_ready_o at a rising edge.
REQ-010 SHALL drive enc_ready_o = !out_full || mem_ready_i (one-entry output register, no bubble).
REQ-011 SHALL encode opcode 0x00 as {opcode,rs,rt,rd,shamt,funct}.
REQ-012 SHALL encode opcodes 0x08, 0x0D, 0x0C, 0x2B, 0x23, 0x04, 0x05 as {opcode,rs,rt,imm}.
REQ-013 SHALL encode opcode 0x0F (LUI) as {opcode,5'b0,rt,imm}, forcing rs to zero.
REQ-014 SHALL register the encoded word and its address, with mem_valid_o asserted the cycle after acceptance (latency 1).
REQ-015 SHALL hold mem_wdata_o and mem_addr_o stable while mem_valid_o && !mem_ready_i.
REQ-016 SHALL keep a state machine with states EMPTY (mem_valid_o=0) and FULL (mem_valid_o=1).
REQ-017 SHALL make these state transitions: EMPTY->FULL on accept; FULL->EMPTY on mem_ready_i without accept; FULL->FULL on mem_ready_i with accept (new word replaces old) or on stall.
REQ-018 SHALL use a write-address counter that is captured into mem_addr_o on accept and advances by 4 on each accept.
REQ-019 SHALL wrap the address counter from 0xFFFF_FFFC to 0x0000_0000.
REQ-020 SHALL, on load_i, set the address counter to {load_addr_i[31:2],2'b00}.
REQ-021 SHALL, on load_i coincident with accept, stamp the accepted word with the loaded address and set the counter to loaded+4.
REQ-022 SHALL leave an already-held FULL word's address unchanged on load_i.
REQ-023 SHALL increment word_cnt_o on each mem_valid_o && mem_ready_i, saturating at 0xFFFF.

Reset
REQ-024 SHALL, with rst_n_i low at an edge, set state to EMPTY and clear mem_valid_o, illegal_o, mem_wdata_o, mem_addr_o, the address counter and word_cnt_o.
REQ-025 SHALL drive enc_ready_o=1 after reset.
REQ-026 SHALL, on reset while FULL, discard the held word with no write performed.

Configuration
REQ-027 SHALL, with INSTR_ENC_OPCODE_CHECK_EN defined, accept-and-drop any opcode outside the set in REQ-011..REQ-013.
REQ-028 SHALL, for such a dropped opcode, pulse illegal_o the next cycle, leave state and counter unchanged, and produce no write.
REQ-029 SHALL, with INSTR_ENC_OPCODE_CHECK_EN undefined, encode unknown opcodes I-format, tie illegal_o to 0 and omit the check logic.

Structure
REQ-030 SHALL take opcode localparams (R_TYPE, ADDI, ORI, ANDI, LUI, SW, LW, BEQ, BNE) and the 32-bit word width from shared package mips_isa_pkg, common with the control decoder.
REQ-031 SHALL place the combinational field packer in one sub-module, instr_field_pack (fields in, 32-bit word plus legal flag out); the FSM, address counter and word counter stay in instr_encoder.

Verification
REQ-032 SHALL cover: reset; load 0x0040_0000; ADDI rs=0 rt=8 imm=5 with mem_ready_i=1 -> cycle+1 mem_wdata_o=0x2008_0005, mem_addr_o=0x0040_0000.
REQ-033 SHALL cover: R-type rs=8 rt=9 rd=10 shamt=0 funct=0x20 -> 0x0109_5020; then LW rs=29 rt=8 imm=4 -> 0x8FA8_0004 at address +4; word_cnt_o=2.
REQ-034 SHALL cover: LUI rs=7 rt=1 imm=0x1001 -> 0x3C01_1001 (rs forced 0).
REQ-035 SHALL cover: mem_ready_i=0 for 5 cycles while FULL -> enc_ready_o=0, outputs stable; one accept with mem_ready_i=1 coincident with a new valid -> back-to-back write, no bubble.
REQ-036 SHALL cover: load 0xFFFF_FFFC, two words -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL cover: with macro, opcode 0x3F -> illegal_o pulse and no mem_valid_o; without macro -> word 0xFC00_0000|{rs,rt,imm} written.
